// File: rtl/enum_pkg.sv
// Shared types and helpers for the minterm enumerator: FSM state encoding,
// default input count and an all-ones mask generator.
package enum_pkg;

  localparam int N_IN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [31:0] ALL_ONES(input int n);
    if (n >= 32) begin
      ALL_ONES = '1;
    end else begin
      ALL_ONES = (32'd1 << n) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/onset_enumerator.sv
// Sweeps every input vector of an external combinational function and streams
// out, in ascending order, each minterm whose output matches the latched polarity.
module onset_enumerator
  import enum_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             polarity,
  output logic [N_IN-1:0]  fn_x,
  input  logic             fn_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N_IN-1:0]  m_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [31:0]     ONES32 = ALL_ONES(N_IN);
  localparam logic [N_IN-1:0] ONES   = ONES32[N_IN-1:0];

  state_t           r_state;
  state_t           w_next_state;
  logic             r_pol;
  logic [N_IN-1:0]  r_fn_x;
  logic [N_IN-1:0]  r_m_data;
  logic             r_m_valid;
  logic [CNT_W-1:0] r_match_cnt;

  logic w_match;
  logic w_last;
  logic w_start_ok;
  logic w_xfer;

  assign w_match    = (fn_y == r_pol);
  assign w_last     = (r_fn_x == ONES);
  assign w_start_ok = start && !abort && ((r_state == IDLE) || (r_state == DONE));
  assign w_xfer     = (r_state == HOLD) && !abort && r_m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) w_next_state = SCAN;
        SCAN: begin
          if (w_match)     w_next_state = HOLD;
          else if (w_last) w_next_state = DONE;
        end
        HOLD: begin
          if (w_xfer) w_next_state = w_last ? DONE : SCAN;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      SCAN, HOLD: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Probe counter stops on the last vector instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pol       <= 1'b1;
      r_fn_x      <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_match_cnt <= '0;
    end else if (w_start_ok) begin
      r_pol       <= polarity;
      r_fn_x      <= '0;
      r_match_cnt <= '0;
    end else if ((r_state == SCAN) && !abort) begin
      if (w_match) begin
        r_m_data  <= r_fn_x;
        r_m_valid <= 1'b1;
      end else if (!w_last) begin
        r_fn_x <= r_fn_x + N_IN'(1);
      end
    end else if (r_state == HOLD) begin
      if (abort) begin
        r_m_valid <= 1'b0;
      end else if (w_xfer) begin
        r_m_valid   <= 1'b0;
        r_match_cnt <= r_match_cnt + CNT_W'(1);
        if (!w_last) r_fn_x <= r_fn_x + N_IN'(1);
      end
    end
  end

  assign fn_x      = r_fn_x;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_onset_enumerator.sv
// Scoreboard bench: a 4-input instance for stream tests and a 16-input instance
// for the full-width sweep and asynchronous reset checks.
module tb_onset_enumerator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0, abort4 = 1'b0, pol4 = 1'b1, ready4 = 1'b1;
  logic       y4, valid4, busy4, done4;
  logic [3:0] x4, data4;
  logic [4:0] cnt4;

  logic        start16 = 1'b0, abort16 = 1'b0, pol16 = 1'b1, ready16 = 1'b1;
  logic        y16, valid16, busy16, done16;
  logic [15:0] x16, data16;
  logic [16:0] cnt16;

  int fsel = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  assign y4  = (fsel == 0) ? (x4[0] & x4[1]) : 1'b1;
  assign y16 = 1'b0;

  onset_enumerator #(.N_IN(4), .CNT_W(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .polarity(pol4),
    .fn_x(x4), .fn_y(y4), .m_valid(valid4), .m_ready(ready4), .m_data(data4),
    .busy(busy4), .done(done4), .match_cnt(cnt4)
  );

  onset_enumerator #(.N_IN(16), .CNT_W(17)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16), .polarity(pol16),
    .fn_x(x16), .fn_y(y16), .m_valid(valid16), .m_ready(ready16), .m_data(data16),
    .busy(busy16), .done(done16), .match_cnt(cnt16)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected minterms on each handshake and checks stall stability.
  logic       pv = 1'b0, pr = 1'b0, pa = 1'b0;
  logic [3:0] pd = 4'd0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr && !pa) begin
        chk("stall_valid", valid4, 1);
        chk("stall_data", data4, pd);
      end
      if (valid4 && ready4) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_minterm: got %0d expected none", data4);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("minterm", data4, e);
          $display("minterm %0d (expected %0d) at %0t", data4, e, $time);
        end
      end
      if (valid16) begin
        n_checks++;
        n_errors++;
        $display("FAIL valid16: got m_valid=1 data=%0d expected no output", data16);
      end
    end
    pv = valid4;
    pr = ready4;
    pa = abort4;
    pd = data4;
  end

  task automatic start_sweep4(input logic pol);
    pol4 = pol;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic start_sweep16(input logic pol);
    pol16 = pol;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic run4(input int limit, input bit toggle, output int n);
    n = 0;
    while (!done4 && n < limit) begin
      ready4 = toggle ? (n % 3 == 2) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("done4_reached", done4, 1);
  endtask

  initial begin
    int n;
    int k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fn_x4", x4, 0);
    chk("rst_valid4", valid4, 0);
    chk("rst_data4", data4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_cnt4", cnt4, 0);
    chk("rst_fn_x16", x16, 0);
    chk("rst_cnt16", cnt16, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: on-set of x0&x1
    fsel = 0;
    exp_q = '{3, 7, 11, 15};
    start_sweep4(1'b1);
    chk("t1_busy", busy4, 1);
    run4(100, 1'b0, n);
    chk("t1_cycles", n, 20);
    chk("t1_cnt", cnt4, 4);
    chk("t1_queue_empty", exp_q.size(), 0);
    $display("T1 done after %0d cycles, match_cnt=%0d", n, cnt4);

    // T2: off-set, restarted from DONE
    exp_q = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14};
    start_sweep4(1'b0);
    run4(100, 1'b0, n);
    chk("t2_cycles", n, 28);
    chk("t2_cnt", cnt4, 12);
    chk("t2_queue_empty", exp_q.size(), 0);
    $display("T2 done after %0d cycles, match_cnt=%0d", n, cnt4);

    // T3: constant-one function with a stalling sink
    fsel = 1;
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    start_sweep4(1'b1);
    run4(300, 1'b1, n);
    chk("t3_cnt", cnt4, 16);
    chk("t3_queue_empty", exp_q.size(), 0);
    $display("T3 done after %0d cycles, match_cnt=%0d", n, cnt4);
    ready4 = 1'b1;
    abort4 = 1'b1;
    @(posedge clk); #1;
    abort4 = 1'b0;
    chk("t3_abort_done", done4, 0);
    chk("t3_abort_busy", busy4, 0);
    chk("t3_abort_cnt_kept", cnt4, 16);
    $display("T3 abort in DONE: done=%0d match_cnt=%0d", done4, cnt4);

    // T5: abort while minterm 7 is stalled
    fsel = 0;
    ready4 = 1'b0;
    exp_q = '{3};
    start_sweep4(1'b1);
    k = 0;
    while (!valid4 && k < 50) begin @(posedge clk); #1; k++; end
    chk("t5_first_data", data4, 3);
    ready4 = 1'b1;
    @(posedge clk); #1;
    ready4 = 1'b0;
    k = 0;
    while (!valid4 && k < 50) begin @(posedge clk); #1; k++; end
    chk("t5_second_data", data4, 7);
    repeat (2) @(posedge clk);
    #1;
    abort4 = 1'b1;
    @(posedge clk); #1;
    abort4 = 1'b0;
    chk("t5_valid_dropped", valid4, 0);
    chk("t5_busy", busy4, 0);
    chk("t5_done", done4, 0);
    chk("t5_cnt", cnt4, 1);
    chk("t5_queue_empty", exp_q.size(), 0);
    $display("T5 abort in HOLD: valid=%0d match_cnt=%0d", valid4, cnt4);
    ready4 = 1'b1;

    // T4: full 16-input sweep with no matches
    start_sweep16(1'b1);
    n = 0;
    while (!done16 && n < 70000) begin @(posedge clk); #1; n++; end
    chk("t4_done", done16, 1);
    chk("t4_cycles", n, 65536);
    chk("t4_cnt", cnt16, 0);
    chk("t4_fn_x_last", x16, 16'hFFFF);
    $display("T4 done after %0d cycles, match_cnt=%0d", n, cnt16);

    // T6: asynchronous reset mid-sweep
    start_sweep16(1'b1);
    k = 0;
    while (x16 != 16'h1234 && k < 16'h2000) begin @(posedge clk); #1; k++; end
    chk("t6_reached_1234", x16, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fn_x", x16, 0);
    chk("t6_rst_busy", busy16, 0);
    chk("t6_rst_done", done16, 0);
    chk("t6_rst_cnt", cnt16, 0);
    chk("t6_rst_valid", valid16, 0);
    chk("t6_rst_data", data16, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_sweep16(1'b1);
    chk("t6_restart_fn_x", x16, 0);
    chk("t6_restart_busy", busy16, 1);
    chk("t6_restart_cnt", cnt16, 0);
    @(posedge clk); #1;
    chk("t6_second_probe", x16, 1);
    abort16 = 1'b1;
    @(posedge clk); #1;
    abort16 = 1'b0;
    chk("t6_abort_busy", busy16, 0);
    $display("T6 reset and restart: fn_x=%0d busy=%0d", x16, busy16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
